// File: rtl/mem_access.sv
// Load/store stage: 1-cycle completion for non-memory ops, REQ/RESP handshake for data memory.
// Backpressure: stall_out holds execute while a request waits for ready or a load waits for data.
module mem_access #(
   parameter int EX_WIDTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pipeline_in_valid,
   input  logic [4:0]          opcode_in,
   input  logic [2:0]          funct_in,
   input  logic                nop_instr_in,
   input  logic [EX_WIDTH:0]   exception_in,
   input  logic                exception_in_valid,
   input  logic [31:0]         result_in,
   input  logic [31:0]         addr_in,
   input  logic [4:0]          rd_addr_in,
   input  logic                halt_in,
   output logic                stall_out,
   output logic                dmem_req_valid,
   input  logic                dmem_req_ready,
   output logic                dmem_req_we,
   output logic [31:0]         dmem_req_addr,
   output logic [31:0]         dmem_req_wdata,
   output logic [3:0]          dmem_req_be,
   input  logic                dmem_resp_valid,
   input  logic [31:0]         dmem_resp_rdata,
   output logic                pipeline_out_valid,
   output logic [4:0]          opcode_out,
   output logic [2:0]          funct_out,
   output logic [4:0]          rd_addr_out,
   output logic                nop_instr_out,
   output logic                halt_out,
   output logic [31:0]         wb_data,
   output logic                wb_en,
   output logic [EX_WIDTH:0]   exception_out,
   output logic                exception_out_valid
);

   localparam logic [4:0] OP_LOAD      = 5'b00000;
   localparam logic [4:0] OP_IMM_ARITH = 5'b00100;
   localparam logic [4:0] OP_AUIPC     = 5'b00101;
   localparam logic [4:0] OP_STORE     = 5'b01000;
   localparam logic [4:0] OP_ARITH     = 5'b01100;
   localparam logic [4:0] OP_LUI       = 5'b01101;
   localparam logic [4:0] OP_JALR      = 5'b11001;
   localparam logic [4:0] OP_JAL       = 5'b11011;

   localparam logic [2:0] F_B  = 3'b000;
   localparam logic [2:0] F_H  = 3'b001;
   localparam logic [2:0] F_W  = 3'b010;
   localparam logic [2:0] F_BU = 3'b100;
   localparam logic [2:0] F_HU = 3'b101;

   localparam logic [EX_WIDTH:0] EXC_ILLEGAL    = (EX_WIDTH+1)'(2);
   localparam logic [EX_WIDTH:0] EXC_LOAD_MISAL = (EX_WIDTH+1)'(4);
   localparam logic [EX_WIDTH:0] EXC_STOR_MISAL = (EX_WIDTH+1)'(6);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   // Everything the completion needs once the execute stage has moved on.
   typedef struct packed {
      logic        we;
      logic [2:0]  funct;
      logic [1:0]  offset;
      logic [4:0]  rd;
      logic [4:0]  opcode;
      logic        halt;
      logic [31:0] result;
   } mem_op_t;

   state_t  state, next_state;
   mem_op_t op_q;

   logic                is_load, is_store, is_mem, funct_ok, misaligned;
   logic                wb_op, wb_ok, exc_vld, accept_mem;
   logic [EX_WIDTH:0]   exc_code;
   logic [31:0]         req_wdata_d;
   logic [3:0]          req_be_d;
   logic [31:0]         shifted, load_data;

   logic                done;
   logic [4:0]          done_opcode, done_rd;
   logic [2:0]          done_funct;
   logic                done_nop, done_halt, done_wb_en, done_exc_vld;
   logic [31:0]         done_wb_data;
   logic [EX_WIDTH:0]   done_exc;

   // Decode of the instruction offered by execute
   always_comb begin
      is_load  = (opcode_in == OP_LOAD);
      is_store = (opcode_in == OP_STORE);
      is_mem   = is_load | is_store;

      case (funct_in)
         F_B, F_H, F_W: funct_ok = 1'b1;
         F_BU, F_HU:    funct_ok = is_load;
         default:       funct_ok = 1'b0;
      endcase

      case (funct_in)
         F_H, F_HU: misaligned = addr_in[0];
         F_W:       misaligned = (addr_in[1:0] != 2'b00);
         default:   misaligned = 1'b0;
      endcase

      exc_vld  = 1'b0;
      exc_code = '0;
      if (exception_in_valid) begin
         exc_vld  = 1'b1;
         exc_code = exception_in;
      end else if (!nop_instr_in && is_mem && !funct_ok) begin
         exc_vld  = 1'b1;
         exc_code = EXC_ILLEGAL;
      end else if (!nop_instr_in && is_mem && misaligned) begin
         exc_vld  = 1'b1;
         exc_code = is_load ? EXC_LOAD_MISAL : EXC_STOR_MISAL;
      end

      case (opcode_in)
         OP_ARITH, OP_IMM_ARITH, OP_LUI, OP_AUIPC,
         OP_JAL, OP_JALR, OP_LOAD: wb_op = 1'b1;
         default:                  wb_op = 1'b0;
      endcase
      wb_ok = wb_op && (rd_addr_in != 5'd0) && !exc_vld && !nop_instr_in;

      accept_mem = (state == IDLE) && pipeline_in_valid && !nop_instr_in && is_mem && !exc_vld;
   end

   // Store lane replication and byte enables
   always_comb begin
      req_wdata_d = 32'd0;
      req_be_d    = 4'b1111;
      if (is_store) begin
         case (funct_in)
            F_B: begin
               req_wdata_d = {4{result_in[7:0]}};
               req_be_d    = 4'b0001 << addr_in[1:0];
            end
            F_H: begin
               req_wdata_d = {2{result_in[15:0]}};
               req_be_d    = 4'b0011 << addr_in[1:0];
            end
            default: begin
               req_wdata_d = result_in;
               req_be_d    = 4'b1111;
            end
         endcase
      end
   end

   // Load alignment and extension from the captured byte offset
   always_comb begin
      shifted = dmem_resp_rdata >> {op_q.offset, 3'b000};
      case (op_q.funct)
         F_B:     load_data = {{24{shifted[7]}}, shifted[7:0]};
         F_BU:    load_data = {24'd0, shifted[7:0]};
         F_H:     load_data = {{16{shifted[15]}}, shifted[15:0]};
         F_HU:    load_data = {16'd0, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      stall_out  = 1'b0;
      case (state)
         IDLE: begin
            if (accept_mem) begin
               next_state = REQ;
               stall_out  = 1'b1;
            end
         end
         REQ: begin
            stall_out = 1'b1;
            if (dmem_req_ready) begin
               next_state = op_q.we ? IDLE : RESP;
               stall_out  = !op_q.we;
            end
         end
         RESP: begin
            stall_out = !dmem_resp_valid;
            if (dmem_resp_valid) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Which instruction, if any, retires at the next edge
   always_comb begin
      done         = 1'b0;
      done_opcode  = op_q.opcode;
      done_funct   = op_q.funct;
      done_rd      = op_q.rd;
      done_nop     = 1'b0;
      done_halt    = op_q.halt;
      done_wb_data = op_q.result;
      done_wb_en   = 1'b0;
      done_exc_vld = 1'b0;
      done_exc     = '0;
      case (state)
         IDLE: begin
            if (pipeline_in_valid && !accept_mem) begin
               done         = 1'b1;
               done_opcode  = opcode_in;
               done_funct   = funct_in;
               done_rd      = rd_addr_in;
               done_nop     = nop_instr_in;
               done_halt    = halt_in;
               done_wb_data = result_in;
               done_wb_en   = wb_ok;
               done_exc_vld = exc_vld;
               done_exc     = exc_code;
            end
         end
         REQ:  done = dmem_req_ready && op_q.we;
         RESP: begin
            done         = dmem_resp_valid;
            done_wb_data = load_data;
            done_wb_en   = (op_q.rd != 5'd0);
         end
         default: done = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q                <= '0;
         dmem_req_valid      <= 1'b0;
         dmem_req_we         <= 1'b0;
         dmem_req_addr       <= 32'd0;
         dmem_req_wdata      <= 32'd0;
         dmem_req_be         <= 4'd0;
         pipeline_out_valid  <= 1'b0;
         opcode_out          <= 5'd0;
         funct_out           <= 3'd0;
         rd_addr_out         <= 5'd0;
         nop_instr_out       <= 1'b0;
         halt_out            <= 1'b0;
         wb_data             <= 32'd0;
         wb_en               <= 1'b0;
         exception_out       <= '0;
         exception_out_valid <= 1'b0;
      end else begin
         if (accept_mem) begin
            op_q.we        <= is_store;
            op_q.funct     <= funct_in;
            op_q.offset    <= addr_in[1:0];
            op_q.rd        <= rd_addr_in;
            op_q.opcode    <= opcode_in;
            op_q.halt      <= halt_in;
            op_q.result    <= result_in;
            dmem_req_valid <= 1'b1;
            dmem_req_we    <= is_store;
            dmem_req_addr  <= {addr_in[31:2], 2'b00};
            dmem_req_wdata <= req_wdata_d;
            dmem_req_be    <= req_be_d;
         end else if (state == REQ && dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
         end

         pipeline_out_valid  <= done;
         wb_en               <= done && done_wb_en;
         exception_out_valid <= done && done_exc_vld;
         if (done) begin
            opcode_out    <= done_opcode;
            funct_out     <= done_funct;
            rd_addr_out   <= done_rd;
            nop_instr_out <= done_nop;
            halt_out      <= done_halt;
            wb_data       <= done_wb_data;
            exception_out <= done_exc;
         end
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: hand-computed vectors for ALU pass-through, stores, loads, exceptions, reset.
module tb_mem_access;

   localparam logic [4:0] OP_LOAD  = 5'b00000;
   localparam logic [4:0] OP_STORE = 5'b01000;
   localparam logic [4:0] OP_ARITH = 5'b01100;

   logic        clk = 1'b0;
   logic        reset;
   logic        pipeline_in_valid;
   logic [4:0]  opcode_in;
   logic [2:0]  funct_in;
   logic        nop_instr_in;
   logic [4:0]  exception_in;
   logic        exception_in_valid;
   logic [31:0] result_in;
   logic [31:0] addr_in;
   logic [4:0]  rd_addr_in;
   logic        halt_in;
   logic        stall_out;
   logic        dmem_req_valid;
   logic        dmem_req_ready;
   logic        dmem_req_we;
   logic [31:0] dmem_req_addr;
   logic [31:0] dmem_req_wdata;
   logic [3:0]  dmem_req_be;
   logic        dmem_resp_valid;
   logic [31:0] dmem_resp_rdata;
   logic        pipeline_out_valid;
   logic [4:0]  opcode_out;
   logic [2:0]  funct_out;
   logic [4:0]  rd_addr_out;
   logic        nop_instr_out;
   logic        halt_out;
   logic [31:0] wb_data;
   logic        wb_en;
   logic [4:0]  exception_out;
   logic        exception_out_valid;

   int checks = 0;
   int errors = 0;

   mem_access dut (
      .clk(clk), .reset(reset),
      .pipeline_in_valid(pipeline_in_valid), .opcode_in(opcode_in), .funct_in(funct_in),
      .nop_instr_in(nop_instr_in), .exception_in(exception_in), .exception_in_valid(exception_in_valid),
      .result_in(result_in), .addr_in(addr_in), .rd_addr_in(rd_addr_in), .halt_in(halt_in),
      .stall_out(stall_out),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_we(dmem_req_we),
      .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
      .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
      .pipeline_out_valid(pipeline_out_valid), .opcode_out(opcode_out), .funct_out(funct_out),
      .rd_addr_out(rd_addr_out), .nop_instr_out(nop_instr_out), .halt_out(halt_out),
      .wb_data(wb_data), .wb_en(wb_en),
      .exception_out(exception_out), .exception_out_valid(exception_out_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      pipeline_in_valid  = 1'b0;
      opcode_in          = 5'd0;
      funct_in           = 3'd0;
      nop_instr_in       = 1'b0;
      exception_in       = 5'd0;
      exception_in_valid = 1'b0;
      result_in          = 32'd0;
      addr_in            = 32'd0;
      rd_addr_in         = 5'd0;
      halt_in            = 1'b0;
      dmem_req_ready     = 1'b0;
      dmem_resp_valid    = 1'b0;
      dmem_resp_rdata    = 32'd0;
   endtask

   task automatic issue(input logic [4:0] op, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] res, input logic [4:0] rd);
      pipeline_in_valid  = 1'b1;
      opcode_in          = op;
      funct_in           = f;
      addr_in            = a;
      result_in          = res;
      rd_addr_in         = rd;
      nop_instr_in       = 1'b0;
      exception_in_valid = 1'b0;
      exception_in       = 5'd0;
      halt_in            = 1'b0;
   endtask

   // Load with immediate ready and a response one cycle after the request is taken.
   task automatic mem_load(input string tag, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] req_addr, input logic [31:0] rdata,
                           input logic [31:0] exp_data);
      issue(OP_LOAD, f, a, 32'h0, 5'd5);
      #1 check({tag, "_stall_accept"}, stall_out, 1);
      tick;
      check({tag, "_req_vld"}, dmem_req_valid, 1);
      check({tag, "_req_we"}, dmem_req_we, 0);
      check({tag, "_req_addr"}, dmem_req_addr, req_addr);
      dmem_req_ready = 1'b1;
      #1 check({tag, "_stall_req"}, stall_out, 1);
      tick;
      dmem_req_ready = 1'b0;
      #1 check({tag, "_req_drop"}, dmem_req_valid, 0);
      check({tag, "_stall_resp"}, stall_out, 1);
      check({tag, "_no_early_pov"}, pipeline_out_valid, 0);
      dmem_resp_valid = 1'b1;
      dmem_resp_rdata = rdata;
      #1 check({tag, "_stall_release"}, stall_out, 0);
      tick;
      pipeline_in_valid = 1'b0;
      dmem_resp_valid   = 1'b0;
      check({tag, "_pov"}, pipeline_out_valid, 1);
      check({tag, "_wb_data"}, wb_data, exp_data);
      check({tag, "_wb_en"}, wb_en, 1);
   endtask

   // Single-cycle op that must raise the given exception without touching memory.
   task automatic exc_op(input string tag, input logic [4:0] op, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] exp_code);
      issue(op, f, a, 32'h55, 5'd6);
      #1 check({tag, "_stall"}, stall_out, 0);
      tick;
      pipeline_in_valid = 1'b0;
      check({tag, "_pov"}, pipeline_out_valid, 1);
      check({tag, "_exc_vld"}, exception_out_valid, 1);
      check({tag, "_exc"}, exception_out, exp_code);
      check({tag, "_wb_en"}, wb_en, 0);
      check({tag, "_no_req"}, dmem_req_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      idle_inputs();
      reset = 1'b1;
      tick;
      tick;
      check("rst_pov", pipeline_out_valid, 0);
      check("rst_req_vld", dmem_req_valid, 0);
      check("rst_wb_en", wb_en, 0);
      check("rst_wb_data", wb_data, 0);
      check("rst_exc_vld", exception_out_valid, 0);
      check("rst_stall", stall_out, 0);
      reset = 1'b0;

      // ADD rd=5
      issue(OP_ARITH, 3'd0, 32'h0, 32'h1234, 5'd5);
      #1 check("add_stall", stall_out, 0);
      tick;
      pipeline_in_valid = 1'b0;
      check("add_pov", pipeline_out_valid, 1);
      check("add_wb_data", wb_data, 32'h1234);
      check("add_wb_en", wb_en, 1);
      check("add_rd", rd_addr_out, 5);
      check("add_opcode", opcode_out, 5'b01100);
      check("add_no_req", dmem_req_valid, 0);
      check("add_stall_after", stall_out, 0);
      tick;
      check("add_pov_pulse", pipeline_out_valid, 0);

      // SB at 0x103, ready arrives in the fourth request cycle
      issue(OP_STORE, 3'b000, 32'h103, 32'hAB, 5'd0);
      #1 check("sb_stall_accept", stall_out, 1);
      tick;
      for (int i = 0; i < 4; i++) begin
         dmem_req_ready = (i == 3);
         #1;
         check("sb_req_vld", dmem_req_valid, 1);
         check("sb_req_we", dmem_req_we, 1);
         check("sb_req_addr", dmem_req_addr, 32'h100);
         check("sb_req_be", dmem_req_be, 4'b1000);
         check("sb_req_wdata", dmem_req_wdata, 32'hABABABAB);
         check("sb_stall", stall_out, (i == 3) ? 0 : 1);
         check("sb_pov_wait", pipeline_out_valid, 0);
         tick;
      end
      pipeline_in_valid = 1'b0;
      dmem_req_ready    = 1'b0;
      check("sb_pov", pipeline_out_valid, 1);
      check("sb_wb_en", wb_en, 0);
      check("sb_req_drop", dmem_req_valid, 0);
      check("sb_exc_vld", exception_out_valid, 0);
      tick;
      check("sb_pov_pulse", pipeline_out_valid, 0);

      // SH at 0x102 with ready in the first request cycle
      issue(OP_STORE, 3'b001, 32'h102, 32'h1234CDEF, 5'd0);
      tick;
      dmem_req_ready = 1'b1;
      #1 check("sh_req_be", dmem_req_be, 4'b1100);
      check("sh_req_wdata", dmem_req_wdata, 32'hCDEFCDEF);
      check("sh_stall", stall_out, 0);
      tick;
      pipeline_in_valid = 1'b0;
      dmem_req_ready    = 1'b0;
      check("sh_pov", pipeline_out_valid, 1);
      check("sh_req_drop", dmem_req_valid, 0);

      // Loads
      mem_load("lb",  3'b000, 32'h102, 32'h100, 32'h00800000, 32'hFFFFFF80);
      mem_load("lbu", 3'b100, 32'h102, 32'h100, 32'h00800000, 32'h00000080);
      mem_load("lh",  3'b001, 32'h102, 32'h100, 32'h80010000, 32'hFFFF8001);
      mem_load("lhu", 3'b101, 32'h102, 32'h100, 32'h80010000, 32'h00008001);
      mem_load("lw",  3'b010, 32'h204, 32'h204, 32'hDEADBEEF, 32'hDEADBEEF);

      // Misaligned and illegal accesses
      exc_op("lw_mis",  OP_LOAD,  3'b010, 32'h202, 32'd4);
      exc_op("sw_mis",  OP_STORE, 3'b010, 32'h201, 32'd6);
      exc_op("sh_mis",  OP_STORE, 3'b001, 32'h101, 32'd6);
      exc_op("lhu_mis", OP_LOAD,  3'b101, 32'h103, 32'd4);
      exc_op("ld_ill",  OP_LOAD,  3'b011, 32'h200, 32'd2);
      exc_op("st_ill",  OP_STORE, 3'b100, 32'h200, 32'd2);

      // Upstream exception passes through unchanged
      issue(OP_ARITH, 3'd0, 32'h0, 32'h77, 5'd9);
      exception_in_valid = 1'b1;
      exception_in       = 5'h0B;
      tick;
      pipeline_in_valid  = 1'b0;
      exception_in_valid = 1'b0;
      check("exin_pov", pipeline_out_valid, 1);
      check("exin_exc", exception_out, 5'h0B);
      check("exin_exc_vld", exception_out_valid, 1);
      check("exin_wb_en", wb_en, 0);

      // Bubble carrying a halt marker
      issue(OP_ARITH, 3'd0, 32'h0, 32'h99, 5'd5);
      nop_instr_in = 1'b1;
      halt_in      = 1'b1;
      tick;
      pipeline_in_valid = 1'b0;
      nop_instr_in      = 1'b0;
      halt_in           = 1'b0;
      check("nop_pov", pipeline_out_valid, 1);
      check("nop_flag", nop_instr_out, 1);
      check("nop_halt", halt_out, 1);
      check("nop_wb_en", wb_en, 0);

      // Reset while waiting for load data, then a late response
      issue(OP_LOAD, 3'b010, 32'h300, 32'h0, 5'd7);
      tick;
      dmem_req_ready = 1'b1;
      tick;
      dmem_req_ready    = 1'b0;
      pipeline_in_valid = 1'b0;
      #1 check("rr_stall_resp", stall_out, 1);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      check("rr_req_vld", dmem_req_valid, 0);
      check("rr_pov_rst", pipeline_out_valid, 0);
      dmem_resp_valid = 1'b1;
      dmem_resp_rdata = 32'hCAFEF00D;
      #1 check("rr_stall_late", stall_out, 0);
      tick;
      dmem_resp_valid = 1'b0;
      check("rr_pov_late", pipeline_out_valid, 0);
      check("rr_wb_en_late", wb_en, 0);
      issue(OP_ARITH, 3'd0, 32'h0, 32'h4242, 5'd3);
      tick;
      pipeline_in_valid = 1'b0;
      check("rr_add_pov", pipeline_out_valid, 1);
      check("rr_add_wb_data", wb_data, 32'h4242);
      check("rr_add_wb_en", wb_en, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The interface SHALL consist of one clock and one reset: clk drives all state, and reset is synchronous and active-high.
REQ-002 Ports SHALL be as follows; data/address 32 bits, EX_WIDTH per def_params:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- pipeline_in_valid  in  1  execute output valid
- opcode_in  in  5  opcode[6:2]
- funct_in  in  3  funct3
- nop_instr_in  in  1  bubble marker
- exception_in / exception_in_valid  in  EX_WIDTH+1 / 1  upstream exception
- result_in  in  32  ALU result / store data
- addr_in  in  32  load/store byte address
- rd_addr_in  in  5  destination register
- halt_in  in  1  halt marker
- stall_out  out  1  hold execute stage
- dmem_req_valid / dmem_req_ready  out/in  1/1  request handshake
- dmem_req_we  out  1  1=store
- dmem_req_addr  out  32  word address, bits[1:0]=0
- dmem_req_wdata / dmem_req_be  out  32/4  store data, byte enables
- dmem_resp_valid / dmem_resp_rdata  in  1/32  load response
- pipeline_out_valid, opcode_out, funct_out, rd_addr_out, nop_instr_out, halt_out  out  registered pass-through
- wb_data / wb_en  out  32/1  writeback value, write enable
- exception_out / exception_out_valid  out  EX_WIDTH+1 / 1

Function
REQ-003 The FSM SHALL have states IDLE, REQ and RESP; accept inputs only in IDLE.
REQ-004 In IDLE, a valid non-memory op, nop, excepted op, or misaligned access SHALL complete in 1 cycle: outputs registered on the next edge, no dmem request.
REQ-005 In IDLE, a valid aligned OP_LOAD/OP_STORE with no exception SHALL capture its fields, go to REQ, and assert dmem_req_valid (registered) from the next cycle.
REQ-006 In REQ, dmem_req_valid and all dmem_req_* SHALL hold stable until dmem_req_ready=1; then a store goes to IDLE with pipeline_out_valid=1 next cycle, and a load goes to RESP with req_valid deasserted.
REQ-007 In RESP, dmem_resp_valid=1 SHALL register formatted load data with pipeline_out_valid=1 next cycle and return to IDLE; dmem_resp_valid SHALL be ignored in IDLE and REQ.
REQ-008 stall_out SHALL be combinational: 1 in IDLE with an accepted memory op; 1 in REQ except store with dmem_req_ready; 1 in RESP except dmem_resp_valid; else 0, so the held instruction is consumed exactly once.
REQ-009 pipeline_out_valid SHALL be a 1-cycle pulse per completed instruction and 0 otherwise.
REQ-010 Misalignment SHALL be: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0; it sets exception_out_valid=1 and exception_out=4 (load) or 6 (store), with wb_en=0.
REQ-011 exception_in_valid=1 SHALL pass exception_in through unchanged, with no memory access and wb_en=0.
REQ-012 Store formatting SHALL be: SB wdata={4{result_in[7:0]}}, be=4'b0001<<addr[1:0]; SH wdata={2{result_in[15:0]}}, be=4'b0011<<addr[1:0]; SW wdata=result_in, be=4'b1111.
REQ-013 Load formatting SHALL shift rdata right by 8*addr[1:0], then apply: LB sign-extend byte; LBU zero-extend byte; LH sign-extend half; LHU zero-extend half; LW full word.
REQ-014 wb_en SHALL be 1 only for OP_ARITH, OP_IMM_ARITH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR or OP_LOAD with rd_addr_in!=0, no exception and nop=0.
REQ-015 For non-load ops, wb_data SHALL equal result_in.
REQ-016 Undefined funct_in on load/store SHALL raise exception code 2 (illegal instruction) with no memory access.
REQ-017 Pass-through fields SHALL be registered with the completing instruction.

Reset
REQ-018 Reset SHALL force state=IDLE and clear every registered output to 0; dmem_req_valid=0 on the following cycle.
REQ-019 Reset mid-transaction SHALL abandon the operation with no output pulse; a late dmem_resp_valid SHALL be ignored.
REQ-020 Reset SHALL have priority over all inputs.

Verification
REQ-021 ADD: rd=5, result_in=0x1234 -> next cycle pipeline_out_valid=1, wb_data=0x1234, wb_en=1, stall_out=0 throughout.
REQ-022 SB: addr=0x103, result_in=0xAB, ready delayed 3 cycles -> req_addr=0x100, be=1000, wdata=0xABABABAB held stable for 4 cycles; stall_out=1 until the ready cycle; completes with wb_en=0.
REQ-023 LB: addr=0x102, rdata=0x00800000 -> wb_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-024 LW: addr=0x202 -> exception_out=4, exception_out_valid=1, no dmem_req_valid, 1-cycle latency.
REQ-025 Reset asserted in RESP, then dmem_resp_valid arrives -> no pipeline_out_valid; the next ADD completes normally.
